// File: rtl/minis08_core.sv
// MiniS08 CPU core: 8-bit accumulator machine (A, HX, SP, PC, C) on a single-master ready/wait bus.
// Define MINIS08_IRQ_EN to add the irq port, the I mask bit and SEI/CLI/RTI.
module minis08_core #(
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned RESET_PC = 'h100,
   parameter int unsigned SP_RESET = 'hFF,
   parameter int unsigned IRQ_VEC  = 'h1FE
) (
   input  logic              clk50,
   input  logic              reset,
   input  logic              cpu_en,
   output logic [ADDR_W-1:0] addr,
   output logic [7:0]        wdata,
   input  logic [7:0]        rdata,
   output logic              rd,
   output logic              wr,
   input  logic              ready,
`ifdef MINIS08_IRQ_EN
   input  logic              irq,
`endif
   output logic [2:0]        state,
   output logic [7:0]        ir
);
   localparam int unsigned       HW     = ADDR_W - 8;
   localparam logic [ADDR_W-1:0] AOne   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] PcRst  = ADDR_W'(RESET_PC);
   localparam logic [ADDR_W-1:0] SpRst  = ADDR_W'(SP_RESET);
   localparam logic [ADDR_W-1:0] IrqVec = ADDR_W'(IRQ_VEC);
`ifdef MINIS08_IRQ_EN
   localparam bit IrqEn = 1'b1;
`else
   localparam bit IrqEn = 1'b0;
`endif

   typedef enum logic [2:0] {
      StReset = 3'd0, StFetch = 3'd1, StS1 = 3'd2, StS2 = 3'd3, StS3 = 3'd4, StS4 = 3'd5
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, sp_q, sp_d, hx_q, hx_d, mar_q, mar_d, mem_ad, sext;
   logic [7:0]        a_q, a_d, ir_q, ir_d, alu_a, pch, hh;
   logic [8:0]        sum9, dif9;
   logic [3:0]        hi, lo;
   logic              c_q, c_d, alu_c, lo_alu, lo_mem, valid, taken, mem_go, adv, take;
`ifdef MINIS08_IRQ_EN
   logic              i_q, i_d, take_q, take_d;
   assign take = take_q;
`else
   assign take = 1'b0;
`endif

   assign hi     = ir_q[7:4];
   assign lo     = ir_q[3:0];
   assign lo_alu = lo inside {4'h0, 4'h4, 4'h6, 4'h8, 4'hA, 4'hB};
   assign lo_mem = lo_alu | (lo inside {4'h7, 4'hE, 4'hF});
   assign sext   = {{HW{rdata[7]}}, rdata};
   assign pch    = 8'(pc_q[ADDR_W-1:8]);
   assign hh     = 8'(hx_q[ADDR_W-1:8]);
   assign sum9   = {1'b0, a_q} + {1'b0, rdata};
   assign dif9   = {1'b0, a_q} - {1'b0, rdata};
   assign adv    = cpu_en & (~(rd | wr) | ready);
   assign state  = state_q;
   assign ir     = ir_q;

   always_comb begin
      valid = 1'b0;
      case (hi)
         4'h2:       valid = lo inside {4'h0, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'hB};
         4'h4:       valid = lo inside {4'h4, 4'h7, 4'h8};
         4'h8:       valid = (lo inside {4'h1, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB}) |
                             (IrqEn & (lo == 4'h0));
         4'h9:       valid = IrqEn & (lo inside {4'hA, 4'hB});
         4'hA:       valid = lo_alu | (lo inside {4'hE, 4'hF});
         4'hB, 4'hF: valid = lo_mem;
         4'hC:       valid = lo_mem | (lo inside {4'hC, 4'hD});
         default:    valid = 1'b0;
      endcase
   end

   always_comb begin
      case (lo)
         4'h0:    taken = 1'b1;
         4'h4:    taken = ~c_q;
         4'h5:    taken = c_q;
         4'h6:    taken = (a_q != 8'h00);
         4'h7:    taken = (a_q == 8'h00);
         4'hA:    taken = ~a_q[7];
         4'hB:    taken = a_q[7];
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      alu_a = a_q;
      alu_c = c_q;
      case (lo)
         4'h0:    begin alu_a = dif9[7:0]; alu_c = dif9[8]; end
         4'h4:    alu_a = a_q & rdata;
         4'h6:    alu_a = rdata;
         4'h8:    alu_a = a_q ^ rdata;
         4'hA:    alu_a = a_q | rdata;
         4'hB:    begin alu_a = sum9[7:0]; alu_c = sum9[8]; end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      sp_d    = sp_q;
      hx_d    = hx_q;
      mar_d   = mar_q;
      a_d     = a_q;
      c_d     = c_q;
      ir_d    = ir_q;
      addr    = '0;
      wdata   = '0;
      rd      = 1'b0;
      wr      = 1'b0;
      mem_go  = 1'b0;
      mem_ad  = '0;
`ifdef MINIS08_IRQ_EN
      i_d     = i_q;
      take_d  = take_q;
`endif
      unique case (state_q)
         StReset: state_d = StFetch;
         StFetch: begin
            state_d = StS1;
            if (!take) begin
               addr = pc_q; rd = 1'b1; ir_d = rdata; pc_d = pc_q + AOne;
            end
         end
         default: begin
            if (take) begin
               // Interrupt entry: push PCL then PCH, vector on the second write
               addr = sp_q; wr = 1'b1; sp_d = sp_q - AOne;
               if (state_q == StS1) begin
                  wdata = pc_q[7:0]; state_d = StS2;
               end else begin
                  wdata = pch; pc_d = IrqVec; state_d = StFetch;
`ifdef MINIS08_IRQ_EN
                  i_d = 1'b1;
`endif
               end
            end else if (!valid) begin
               state_d = StFetch;
            end else begin
               case (hi)
                  4'h2: begin
                     addr = pc_q; rd = 1'b1; state_d = StFetch;
                     pc_d = taken ? pc_q + AOne + sext : pc_q + AOne;
                  end
                  4'h4: begin
                     state_d = StFetch;
                     case (lo)
                        4'h4:    begin a_d = {1'b0, a_q[7:1]};     c_d = a_q[0]; end
                        4'h7:    begin a_d = {a_q[7], a_q[7:1]};   c_d = a_q[0]; end
                        default: begin a_d = {a_q[6:0], 1'b0};     c_d = a_q[7]; end
                     endcase
                  end
                  4'h8: begin
                     if (lo inside {4'h7, 4'h9, 4'hB}) begin
                        addr = sp_q; wr = 1'b1; sp_d = sp_q - AOne; state_d = StFetch;
                        wdata = (lo == 4'h7) ? a_q : (lo == 4'h9) ? hx_q[7:0] : hh;
                     end else if (state_q == StS1) begin
                        sp_d = sp_q + AOne; state_d = StS2;
                     end else begin
                        addr = sp_q; rd = 1'b1; state_d = StFetch;
                        case (lo)
                           4'h6: a_d = rdata;
                           4'h8: hx_d[7:0] = rdata;
                           4'hA: hx_d[ADDR_W-1:8] = rdata[HW-1:0];
                           default: begin
                              if (state_q == StS2) begin
                                 pc_d[ADDR_W-1:8] = rdata[HW-1:0];
                                 sp_d = sp_q + AOne; state_d = StS3;
                              end else begin
                                 pc_d[7:0] = rdata;
`ifdef MINIS08_IRQ_EN
                                 if (lo == 4'h0) i_d = 1'b0;
`endif
                              end
                           end
                        endcase
                     end
                  end
                  4'h9: begin
                     state_d = StFetch;
`ifdef MINIS08_IRQ_EN
                     i_d = lo[0];
`endif
                  end
                  4'hA: begin
                     addr = pc_q; rd = 1'b1; pc_d = pc_q + AOne; state_d = StFetch;
                     case (lo)
                        4'hE:    hx_d[7:0] = rdata;
                        4'hF:    hx_d = hx_q + sext;
                        default: begin a_d = alu_a; c_d = alu_c; end
                     endcase
                  end
                  4'hB: begin
                     if (state_q == StS1) begin
                        addr = pc_q; rd = 1'b1; pc_d = pc_q + AOne; state_d = StS2;
                        mar_d = {{HW{1'b0}}, rdata};
                     end else begin
                        mem_go = 1'b1; mem_ad = mar_q;
                     end
                  end
                  4'hC: begin
                     case (state_q)
                        StS1: begin
                           addr = pc_q; rd = 1'b1; pc_d = pc_q + AOne; state_d = StS2;
                           mar_d = {rdata[HW-1:0], mar_q[7:0]};
                        end
                        StS2: begin
                           addr = pc_q; rd = 1'b1; pc_d = pc_q + AOne; state_d = StS3;
                           mar_d[7:0] = rdata;
                        end
                        StS3: begin
                           if (lo == 4'hC) begin
                              pc_d = mar_q; state_d = StFetch;
                           end else if (lo == 4'hD) begin
                              addr = sp_q; wr = 1'b1; wdata = pc_q[7:0];
                              sp_d = sp_q - AOne; state_d = StS4;
                           end else begin
                              mem_go = 1'b1; mem_ad = mar_q;
                           end
                        end
                        default: begin
                           addr = sp_q; wr = 1'b1; wdata = pch;
                           sp_d = sp_q - AOne; pc_d = mar_q; state_d = StFetch;
                        end
                     endcase
                  end
                  default: begin
                     mem_go = 1'b1; mem_ad = hx_q;
                  end
               endcase
            end
         end
      endcase

      if (mem_go) begin
         addr = mem_ad; state_d = StFetch;
         case (lo)
            4'h7:    begin wr = 1'b1; wdata = a_q; end
            4'hF:    begin wr = 1'b1; wdata = hx_q[7:0]; end
            4'hE:    begin rd = 1'b1; hx_d[7:0] = rdata; end
            default: begin rd = 1'b1; a_d = alu_a; c_d = alu_c; end
         endcase
      end
`ifdef MINIS08_IRQ_EN
      // irq is only looked at on the way into FETCH
      if (state_d == StFetch) take_d = irq & ~i_d;
`endif
   end

   always_ff @(posedge clk50) begin
      if (reset) begin
         state_q <= StReset;
         pc_q    <= PcRst;
         sp_q    <= SpRst;
         hx_q    <= '0;
         mar_q   <= '0;
         a_q     <= '0;
         c_q     <= 1'b0;
         ir_q    <= '0;
`ifdef MINIS08_IRQ_EN
         i_q     <= 1'b1;
         take_q  <= 1'b0;
`endif
      end else if (adv) begin
         state_q <= state_d;
         pc_q    <= pc_d;
         sp_q    <= sp_d;
         hx_q    <= hx_d;
         mar_q   <= mar_d;
         a_q     <= a_d;
         c_q     <= c_d;
         ir_q    <= ir_d;
`ifdef MINIS08_IRQ_EN
         i_q     <= i_d;
         take_q  <= take_d;
`endif
      end
   end
endmodule

// File: tb/tb_minis08_core.sv
// Directed bench for minis08_core: runs a small program from reset against a 1 KiB memory model
// and checks registers, bus handshake, stack traffic and reset in the middle of JSR.
module tb_minis08_core;
   localparam int unsigned AW = 10;

   logic          clk50 = 1'b0, reset = 1'b1, cpu_en = 1'b1, ready = 1'b1;
   logic [AW-1:0] addr;
   logic [7:0]    wdata, rdata, ir;
   logic          rd, wr;
   logic [2:0]    state;
`ifdef MINIS08_IRQ_EN
   logic          irq = 1'b0;
`endif
   logic [7:0]    mem [0:(1<<AW)-1];
   logic          poke_en = 1'b0;
   logic [AW-1:0] poke_a = '0;
   logic [7:0]    poke_d = '0;
   int            checks = 0, errors = 0, reads = 0, rd_base = 0;

   logic [7:0] prog0 [13] = '{8'hA6, 8'h5A, 8'hA6, 8'hF0, 8'hAB, 8'h20, 8'h25, 8'hFC,
                              8'h27, 8'h05, 8'hCC, 8'h01, 8'h20};
   logic [7:0] prog1 [23] = '{8'hCD, 8'h02, 8'h34, 8'hB7, 8'h40, 8'h44, 8'h48, 8'hA0,
                              8'h31, 8'hAE, 8'h40, 8'hF6, 8'h87, 8'hA6, 8'h00, 8'h86,
                              8'h9D, 8'h20, 8'h01, 8'hFF, 8'hCD, 8'h03, 8'h00};

   always #5 clk50 = ~clk50;

   minis08_core #(.ADDR_W(AW), .RESET_PC('h100), .SP_RESET('hFF), .IRQ_VEC('h1FE)) dut (
      .clk50(clk50), .reset(reset), .cpu_en(cpu_en), .addr(addr), .wdata(wdata),
      .rdata(rdata), .rd(rd), .wr(wr), .ready(ready),
`ifdef MINIS08_IRQ_EN
      .irq(irq),
`endif
      .state(state), .ir(ir)
   );

   assign rdata = mem[addr];

   always @(posedge clk50) begin
      if (poke_en) mem[poke_a] <= poke_d;
      else if (wr && ready && cpu_en && !reset) mem[addr] <= wdata;
      if (rd && ready && cpu_en && !reset) reads <= reads + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
      poke_a = a; poke_d = d; poke_en = 1'b1;
      @(negedge clk50);
      poke_en = 1'b0;
   endtask

   // Run from the current point to the next FETCH and check the number of states taken.
   task automatic run_instr(input string tag, input int exp_n);
      int n = 0;
      do begin
         @(negedge clk50);
         n++;
      end while (state !== 3'd1 && n < 12);
      chk({tag, " states"}, n, exp_n);
   endtask

   initial begin
      @(negedge clk50);
      for (int i = 0; i < 13; i++) poke(AW'(32'h100 + i), prog0[i]);
      for (int i = 0; i < 23; i++) poke(AW'(32'h120 + i), prog1[i]);
      poke(10'h234, 8'h81);

      chk("rst state", state, 3'd0);
      chk("rst rd", rd, 1'b0);
      chk("rst wr", wr, 1'b0);
      chk("rst addr", addr, 10'h000);
      chk("rst pc", dut.pc_q, 10'h100);
      chk("rst sp", dut.sp_q, 10'h0FF);
      chk("rst a", dut.a_q, 8'h00);
      chk("rst ir", ir, 8'h00);

      ready = 1'b0; reset = 1'b0; rd_base = reads;
      @(negedge clk50);
      chk("boot state", state, 3'd1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk50);
         chk("wait addr", addr, 10'h100);
         chk("wait rd", rd, 1'b1);
         chk("wait ir", ir, 8'h00);
         chk("wait pc", dut.pc_q, 10'h100);
      end
      ready = 1'b1;

      run_instr("lda5a", 2);
      chk("lda5a a", dut.a_q, 8'h5A);
      chk("lda5a pc", dut.pc_q, 10'h102);
      chk("lda5a c", dut.c_q, 1'b0);
      chk("lda5a ir", ir, 8'hA6);
      chk("lda5a reads", reads - rd_base, 2);

      cpu_en = 1'b0;
      repeat (2) @(negedge clk50);
      chk("cpu_en hold state", state, 3'd1);
      chk("cpu_en hold pc", dut.pc_q, 10'h102);
      cpu_en = 1'b1;

      run_instr("ldaf0", 2);     chk("ldaf0 a", dut.a_q, 8'hF0);
      run_instr("add", 2);       chk("add a", dut.a_q, 8'h10);
      chk("add c", dut.c_q, 1'b1);
      run_instr("bcs taken", 2); chk("bcs taken pc", dut.pc_q, 10'h104);
      run_instr("add2", 2);      chk("add2 a", dut.a_q, 8'h30);
      chk("add2 c", dut.c_q, 1'b0);
      run_instr("bcs nt", 2);    chk("bcs nt pc", dut.pc_q, 10'h108);
      run_instr("beq nt", 2);    chk("beq nt pc", dut.pc_q, 10'h10A);
      run_instr("jmp", 4);       chk("jmp pc", dut.pc_q, 10'h120);
      run_instr("jsr", 5);       chk("jsr pc", dut.pc_q, 10'h234);
      chk("jsr sp", dut.sp_q, 10'h0FD);
      chk("jsr pcl", mem[10'h0FF], 8'h23);
      chk("jsr pch", mem[10'h0FE], 8'h01);
      run_instr("rts", 4);       chk("rts pc", dut.pc_q, 10'h123);
      chk("rts sp", dut.sp_q, 10'h0FF);
      run_instr("sta", 3);       chk("sta mem", mem[10'h040], 8'h30);
      run_instr("lsra", 2);      chk("lsra a", dut.a_q, 8'h18);
      chk("lsra c", dut.c_q, 1'b0);
      run_instr("lsla", 2);      chk("lsla a", dut.a_q, 8'h30);
      run_instr("sub", 2);       chk("sub a", dut.a_q, 8'hFF);
      chk("sub c", dut.c_q, 1'b1);
      run_instr("ldx", 2);       chk("ldx hx", dut.hx_q, 10'h040);
      run_instr("lda ix", 2);    chk("lda ix a", dut.a_q, 8'h30);
      run_instr("psha", 2);      chk("psha mem", mem[10'h0FF], 8'h30);
      chk("psha sp", dut.sp_q, 10'h0FE);
      run_instr("lda0", 2);      chk("lda0 a", dut.a_q, 8'h00);
      chk("lda0 c", dut.c_q, 1'b1);
      run_instr("pula", 3);      chk("pula a", dut.a_q, 8'h30);
      chk("pula sp", dut.sp_q, 10'h0FF);
      run_instr("nop", 2);       chk("nop pc", dut.pc_q, 10'h131);
      run_instr("bra", 2);       chk("bra pc", dut.pc_q, 10'h134);

      repeat (3) @(negedge clk50);
      chk("jsr s3 state", state, 3'd4);
      chk("jsr s3 wr", wr, 1'b1);
      chk("jsr s3 addr", addr, 10'h0FF);
      chk("jsr s3 wdata", wdata, 8'h37);
      reset = 1'b1;
      @(negedge clk50);
      chk("midrst state", state, 3'd0);
      chk("midrst rd", rd, 1'b0);
      chk("midrst wr", wr, 1'b0);
      chk("midrst pc", dut.pc_q, 10'h100);
      chk("midrst sp", dut.sp_q, 10'h0FF);

`ifdef MINIS08_IRQ_EN
      poke(10'h100, 8'h9A);
      poke(10'h1FE, 8'h80);
      irq = 1'b1; reset = 1'b0;
      run_instr("boot", 1);
      run_instr("cli", 2);
      run_instr("irq", 3);
      chk("irq pc", dut.pc_q, 10'h1FE);
      chk("irq i", dut.i_q, 1'b1);
      chk("irq sp", dut.sp_q, 10'h0FD);
      chk("irq pcl", mem[10'h0FF], 8'h01);
      chk("irq pch", mem[10'h0FE], 8'h01);
      irq = 1'b0;
      run_instr("rti", 4);
      chk("rti pc", dut.pc_q, 10'h101);
      chk("rti i", dut.i_q, 1'b0);
      chk("rti sp", dut.sp_q, 10'h0FF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
